// File: rtl/ms_display_driver.sv
// Millisecond display driver: captures a binary 0..999 count, converts it to
// BCD with a sequential shift-add-3 engine, and multiplexes three common-anode
// seven-segment digits with optional leading-zero blanking.
module ms_display_driver #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic [9:0]  value,
  input  logic        valid,
  output logic        ready,
  output logic [11:0] bcd,
  output logic        bcd_valid,
  output logic        ovf,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  typedef enum logic {IDLE, CONV} state_t;
  typedef enum logic [1:0] {DIG_U = 2'd0, DIG_T = 2'd1, DIG_H = 2'd2} digit_t;

  localparam logic [15:0] SCAN_LAST = 16'(SCAN_DIV - 1);
  localparam logic [3:0]  ITER_LAST = 4'd9;

  state_t      state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [9:0]  bin_q, bin_d;
  logic [11:0] work_q, work_d;
  logic        pend_ovf_q, pend_ovf_d;
  logic [11:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;
  logic        bcd_valid_q, bcd_valid_d;

  logic [15:0] scan_cnt_q, scan_cnt_d;
  digit_t      digit_q, digit_d;
  logic [2:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic [11:0] work_adj;
  logic [11:0] work_shift;
  logic [9:0]  bin_shift;
  logic [3:0]  nib;
  logic        blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // One double-dabble step: correct each nibble, then shift the joint register.
  always_comb begin
    work_adj   = {add3(work_q[11:8]), add3(work_q[7:4]), add3(work_q[3:0])};
    work_shift = {work_adj[10:0], bin_q[9]};
    bin_shift  = {bin_q[8:0], 1'b0};
  end

  // Conversion controller: capture in IDLE, ten iterations in CONV, then commit.
  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    bin_d       = bin_q;
    work_d      = work_q;
    pend_ovf_d  = pend_ovf_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) begin
          state_d = CONV;
          iter_d  = 4'd0;
          work_d  = 12'd0;
          if (value > 10'd999) begin
            bin_d      = 10'd999;
            pend_ovf_d = 1'b1;
          end else begin
            bin_d      = value;
            pend_ovf_d = 1'b0;
          end
        end
      end
      CONV: begin
        work_d = work_shift;
        bin_d  = bin_shift;
        iter_d = iter_q + 4'd1;
        // The final step's result goes straight to the committed outputs so
        // partial BCD never reaches bcd or the display.
        if (iter_q == ITER_LAST) begin
          bcd_d       = work_shift;
          ovf_d       = pend_ovf_q;
          bcd_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan: fixed dwell per digit, outputs registered from the next digit
  // so an, seg and dp always agree with each other.
  always_comb begin
    scan_cnt_d = scan_cnt_q + 16'd1;
    digit_d    = digit_q;
    if (scan_cnt_q >= SCAN_LAST) begin
      scan_cnt_d = 16'd0;
      case (digit_q)
        DIG_U:   digit_d = DIG_T;
        DIG_T:   digit_d = DIG_H;
        default: digit_d = DIG_U;
      endcase
    end
    nib   = bcd_q[3:0];
    blank = 1'b0;
    an_d  = 3'b110;
    case (digit_d)
      DIG_T: begin
        nib   = bcd_q[7:4];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
        an_d  = 3'b101;
      end
      DIG_H: begin
        nib   = bcd_q[11:8];
        blank = (BLANK_LZ != 0) && (bcd_q[11:8] == 4'd0);
        an_d  = 3'b011;
      end
      default: begin
        nib   = bcd_q[3:0];
        blank = 1'b0;
        an_d  = 3'b110;
      end
    endcase
    seg_d = blank ? 7'h7F : seg_decode(nib);
    dp_d  = !((digit_d == DIG_H) && ovf_q);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= IDLE;
      iter_q      <= 4'd0;
      bin_q       <= 10'd0;
      work_q      <= 12'd0;
      pend_ovf_q  <= 1'b0;
      bcd_q       <= 12'h000;
      ovf_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
      scan_cnt_q  <= 16'd0;
      digit_q     <= DIG_U;
      an_q        <= 3'b110;
      seg_q       <= 7'h40;
      dp_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      bin_q       <= bin_d;
      work_q      <= work_d;
      pend_ovf_q  <= pend_ovf_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      bcd_valid_q <= bcd_valid_d;
      scan_cnt_q  <= scan_cnt_d;
      digit_q     <= digit_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign bcd       = bcd_q;
  assign ovf       = ovf_q;
  assign bcd_valid = bcd_valid_q;
  assign an        = an_q;
  assign seg       = seg_q;
  assign dp        = dp_q;

endmodule

// File: tb/tb_ms_display_driver.sv
// Directed bench for ms_display_driver with a scoreboard of expected commits.
module tb_ms_display_driver;

  logic        clk;
  logic        clrn;
  logic [9:0]  value;
  logic        valid;
  logic        ready;
  logic [11:0] bcd;
  logic        bcd_valid;
  logic        ovf;
  logic [2:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] b;
    logic        o;
    int          c;
  } exp_t;
  exp_t sb[$];

  ms_display_driver #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
    .clk(clk), .clrn(clrn), .value(value), .valid(valid), .ready(ready),
    .bcd(bcd), .bcd_valid(bcd_valid), .ovf(ovf), .an(an), .seg(seg), .dp(dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_bcd(input int v);
    int c;
    c = (v > 999) ? 999 : v;
    return {4'(c / 100), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  function automatic logic [6:0] seg_of(input logic [3:0] n);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return (n < 4'd10) ? tbl[n] : 7'h7F;
  endfunction

  task automatic push(input int v);
    exp_t e;
    e.b = exp_bcd(v);
    e.o = (v > 999);
    e.c = cyc;
    sb.push_back(e);
  endtask

  // Commit monitor: every bcd_valid must match the oldest outstanding capture.
  always @(negedge clk) begin
    if (clrn && bcd_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_bcd_valid", bcd_valid, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("commit_latency", cyc, e.c + 10);
        chk("commit_bcd", bcd, e.b);
        chk("commit_ovf", ovf, e.o);
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ready_timeout", n < 50, 1);
  endtask

  task automatic send(input int v);
    wait_ready();
    value = 10'(v);
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    push(v);
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_ready"}, ready, 1);
    chk({tag, "_bcd"}, bcd, 12'h000);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_bcd_valid"}, bcd_valid, 0);
    chk({tag, "_an"}, an, 3'b110);
    chk({tag, "_seg"}, seg, 7'h40);
    chk({tag, "_dp"}, dp, 1);
  endtask

  task automatic scan_chk(input string tag, input logic [11:0] b, input logic o);
    logic [6:0] es [3];
    logic [2:0] ea [3];
    logic [2:0] prev;
    int n;
    es[0] = seg_of(b[3:0]);
    es[1] = (b[11:8] == 4'd0 && b[7:4] == 4'd0) ? 7'h7F : seg_of(b[7:4]);
    es[2] = (b[11:8] == 4'd0) ? 7'h7F : seg_of(b[11:8]);
    ea = '{3'b110, 3'b101, 3'b011};
    prev = 3'b111;
    n = 0;
    @(negedge clk);
    while (!(an === 3'b110 && prev === 3'b011) && n < 40) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    chk({tag, "_sync"}, n < 40, 1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      chk({tag, "_an"}, an, ea[i / 4]);
      chk({tag, "_seg"}, seg, es[i / 4]);
      chk({tag, "_dp"}, dp, (i / 4 == 2 && o) ? 0 : 1);
    end
  endtask

  initial begin
    int n;
    clrn  = 1'b0;
    valid = 1'b0;
    value = 10'd0;
    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    #2 clrn = 1'b1;

    // Zero: only the units digit lit.
    send(0);
    wait_edges(10);
    chk("zero_bcd_valid", bcd_valid, 1);
    chk("zero_bcd", bcd, 12'h000);
    scan_chk("zero_scan", 12'h000, 1'b0);

    // 999: ready low for ten cycles, commit on the tenth edge.
    send(999);
    for (int i = 0; i < 10; i++) begin
      chk("n999_ready_low", ready, 0);
      @(posedge clk); #1;
    end
    chk("n999_ready_back", ready, 1);
    chk("n999_bcd_valid", bcd_valid, 1);
    chk("n999_bcd", bcd, 12'h999);
    chk("n999_ovf", ovf, 0);
    @(posedge clk); #1;
    chk("n999_pulse_end", bcd_valid, 0);
    chk("n999_hold", bcd, 12'h999);

    // Overflow clamp with decimal point on the hundreds slot.
    send(1023);
    wait_edges(10);
    chk("ovf_bcd", bcd, 12'h999);
    chk("ovf_flag", ovf, 1);
    scan_chk("ovf_scan", 12'h999, 1'b1);

    // Held valid during conversion: second capture only at N+11.
    wait_ready();
    value = 10'd405;
    valid = 1'b1;
    @(posedge clk); #1;
    push(405);
    value = 10'd7;
    wait_edges(10);
    chk("hold_ready", ready, 1);
    chk("hold_bcd_first", bcd, 12'h405);
    chk("hold_ovf_cleared", ovf, 0);
    @(posedge clk); #1;
    push(7);
    valid = 1'b0;
    chk("hold_second_busy", ready, 0);
    chk("hold_bcd_kept", bcd, 12'h405);
    wait_edges(10);
    chk("hold_bcd_second", bcd, 12'h007);
    scan_chk("seven_scan", 12'h007, 1'b0);

    // Digit order and dwell with mixed zero positions.
    send(120);
    wait_edges(10);
    chk("n120_bcd", bcd, 12'h120);
    scan_chk("n120_scan", 12'h120, 1'b0);

    // Back-to-back pseudo-random values through the scoreboard.
    for (int k = 0; k < 12; k++) send(int'($urandom_range(0, 1023)));
    wait_edges(12);

    // Reset, then abort a conversion at iteration 5.
    @(posedge clk); #1;
    clrn = 1'b0;
    #2 reset_checks("rst1");
    #1 clrn = 1'b1;
    send(555);
    wait_edges(5);
    clrn = 1'b0;
    #1;
    reset_checks("abort");
    sb.delete();
    #2 clrn = 1'b1;
    wait_edges(15);
    chk("abort_bcd_kept", bcd, 12'h000);
    chk("abort_ready", ready, 1);

    // First capture after the abort behaves as from power-up.
    send(42);
    wait_edges(10);
    chk("post_bcd", bcd, 12'h042);
    chk("post_bcd_valid", bcd_valid, 1);
    scan_chk("post_scan", 12'h042, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ms_display_driver.md
MS_DISPLAY_DRIVER -- requirements
Module: ms_display_driver

Interface
REQ-001 Parameter SCAN_DIV, default 1000, meaning clk cycles each digit stays enabled (legal range 2..65535).
REQ-002 Parameter BLANK_LZ, default 1, meaning leading-zero blanking enable (1=on, 0=off).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 clrn  input  1  reset, asynchronous, active-low.
REQ-005 value  input  10  binary millisecond count to display, nominal 0..999.
REQ-006 valid  input  1  value is presented for capture.
REQ-007 ready  output  1  block can accept a value.
REQ-008 bcd  output  12  committed result: [11:8] hundreds, [7:4] tens, [3:0] units.
REQ-009 bcd_valid  output  1  one-cycle pulse when bcd is updated.
REQ-010 ovf  output  1  committed value was above 999 and was clamped.
REQ-011 an  output  3  active-low digit enable: bit0 units, bit1 tens, bit2 hundreds.
REQ-012 seg  output  7  active-low segments, bit0=a through bit6=g.
REQ-013 dp  output  1  active-low decimal point.

Function
REQ-014 Handshake SHALL capture value on a rising edge with valid=1 and ready=1; valid with ready=0 SHALL be ignored and not queued.
REQ-015 Capture SHALL clamp to 999 with a pending ovf flag when value>999; otherwise it passes the value unchanged with pending ovf=0.
REQ-016 Controller states SHALL be IDLE (ready=1) and CONV (ready=0); capture moves IDLE->CONV with iteration count 0.
REQ-017 CONV SHALL perform exactly one shift-add-3 iteration per cycle for 10 cycles: add 3 to each BCD nibble >=5, then shift {bcd_work, bin_work} left by 1.
REQ-018 On the 10th CONV edge, bcd, ovf and bcd_valid=1 SHALL update together, and the state returns to IDLE (ready=1) on the same edge.
REQ-019 Latency: a value captured at edge N SHALL be committed at edge N+10, and bcd_valid SHALL be high for exactly cycle N+10..N+11; the earliest next capture is edge N+11.
REQ-020 bcd and ovf SHALL hold their committed values between commits; intermediate CONV contents SHALL never appear on bcd, seg or dp.
REQ-021 Scan counter SHALL count 0..SCAN_DIV-1 and wrap; on wrap, digit index advances units->tens->hundreds->units.
REQ-022 an SHALL be one-hot low for the current digit (110, 101, 011), with no all-high or multi-low cycles outside reset.
REQ-023 seg SHALL decode the selected nibble: 0=40h, 1=79h, 2=24h, 3=30h, 4=19h, 5=12h, 6=02h, 7=78h, 8=00h, 9=10h.
REQ-024 When BLANK_LZ=1, seg SHALL be 7Fh on the hundreds digit if hundreds=0 and on the tens digit if hundreds=0 and tens=0; units SHALL never be blanked.
REQ-025 dp SHALL be 0 only while the hundreds digit is selected and ovf=1; otherwise dp=1.
REQ-026 seg, an and dp SHALL be registered outputs.
REQ-027 Scan operation SHALL run independently of conversion; a commit coinciding with a digit switch takes effect on the new digit's next cycle.

Reset
REQ-028 clrn=0 SHALL immediately force state IDLE, ready=1, bcd=000h, ovf=0, bcd_valid=0, scan count 0, digit units, an=110, seg=40h, dp=1.
REQ-029 Reset during CONV SHALL abort the conversion without committing; after release, the first capture behaves as from power-up.

Verification
REQ-030 Reset then value=0 capture -> bcd=000h at edge N+10, units shows 40h, tens/hundreds 7Fh.
REQ-031 value=999 captured at edge N -> ready low cycles N..N+9, bcd=999h and bcd_valid pulse at edge N+10, ovf=0.
REQ-032 value=1023 -> bcd=999h, ovf=1, dp=0 only during hundreds scan slot.
REQ-033 value=405 then valid held through CONV with value=7 -> second capture only at N+11, giving bcd=405h then 007h; 007h displays units 78h, tens and hundreds blanked.
REQ-034 clrn pulse at CONV iteration 5 -> no bcd_valid, bcd remains 000h, ready=1 immediately.
REQ-035 SCAN_DIV=4, bcd=120h -> an sequence 110,101,011 every 4 cycles with seg 40h, 24h, 79h.
